expr_eval: RTL and testbench
============================

EXPR_EVAL -- requirements
Module: expr_eval

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 clr  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  when high, in carries one ASCII character that is consumed on this clk edge.
REQ-004 in  input  8  ASCII character: '0'-'9', '+', '*', '(', ')' or '='.
REQ-005 result  output  16  value of the last correctly terminated expression, unsigned, modulo 2^16.
REQ-006 done  output  1  one-cycle pulse; result is valid and newly updated.
REQ-007 err  output  1  one-cycle pulse; a syntax error was detected.
REQ-008 busy  output  1  high while an expression is partially received (any state other than S_OPND with no accepted character).

Function
REQ-009 Grammar: expr = operand (op operand)* '='; op = '+' | '*'; operand = digit | '(' digit (op digit)+ ')'.
REQ-010 No nested parentheses; each paren group contains at least one operator.
REQ-011 Digits are single characters with values 0-9.
REQ-012 '*' binds tighter than '+', both inside and outside parentheses; evaluation is left to right.
REQ-013 Evaluation registers: sum16, term16, mulpend. On an outer '(' the values of sum, term and mulpend are saved to shadow registers.
REQ-014 Operand value v at operand position: term <= mulpend ? term*v : v. The product is truncated to 16 bits.
REQ-015 On '+': sum <= sum+term (mod 2^16) and mulpend <= 0. On '*': mulpend <= 1.
REQ-016 On '(': save sum, term and mulpend; then inner sum <= 0 and mulpend <= 0.
REQ-017 On ')': v = inner sum+term; restore the outer registers; apply REQ-014 with v.
REQ-018 On '=': result <= sum+term, and done pulses on the same edge (latency 1 clk from the '=' edge to done visible). The evaluator then returns to S_OPND with sum=0 and mulpend=0.
REQ-019 FSM states:
- S_OPND: digit -> S_OP; '(' -> S_PD1.
- S_OP: op -> S_OPND; '=' -> done, then S_OPND.
- S_PD1: digit -> S_PO1.
- S_PO1: op -> S_PD2.
- S_PD2: digit -> S_PO2.
- S_PO2: op -> S_PD2; ')' -> S_OP.
- S_DRAIN: see REQ-020.
REQ-020 Any character not listed for the current state raises err for one cycle, and the FSM enters S_DRAIN.
REQ-021 In S_DRAIN all characters are ignored until '='. That '=' returns the FSM to S_OPND with no done pulse and result unchanged.
REQ-022 While in_valid is low, the state, the evaluation registers and result do not change, and done/err stay low.
REQ-023 done and err are never high in the same cycle.
REQ-024 result holds its value between done pulses.

Reset
REQ-025 clr asserted forces the following values immediately, without a clock:
- state = S_OPND
- sum, term and all shadow registers = 0
- mulpend = 0
- result = 0
- done = 0, err = 0, busy = 0
REQ-026 A clr mid-expression discards all partial evaluation; the next character is parsed as the start of a new expression.

Structure
REQ-027 Package expr_pkg holds the ASCII constants ('0', '9', '+', '*', '(', ')', '=') and the state enumeration.
REQ-028 Sub-module ascii_digit: combinational; takes in[7:0] and outputs is_digit and val[3:0]; instantiated once.
REQ-029 The evaluation datapath, the FSM and the output registers live in expr_eval.

Verification
REQ-030 "2+3*4=" -> one done pulse, result=14, err never high.
REQ-031 "(1+2)*3=" then "4*(2+3*2)+1=" -> results 9 then 33, in that order, each with a single done pulse.
REQ-032 "9*9*9*9*9*9=" -> result=7153 (531441 mod 65536).
REQ-033 "(3)=" -> err pulse on the ')' edge; no done; a following "1=" -> result=1.
REQ-034 "2+a5=" -> err on 'a'; the '=' gives no done; result keeps its previous value.
REQ-035 "2+3", then clr pulse, then "4=" -> result=4; in_valid gaps inserted between characters do not change the outcome.

Source files
------------

// File: rtl/expr_pkg.sv
//------------------------------------------------------------------------------
// expr_pkg : ASCII constants and FSM state encoding for the expression evaluator
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package expr_pkg;

    localparam logic [7:0] c_zero  = 8'h30;
    localparam logic [7:0] c_nine  = 8'h39;
    localparam logic [7:0] c_plus  = 8'h2B;
    localparam logic [7:0] c_star  = 8'h2A;
    localparam logic [7:0] c_lpar  = 8'h28;
    localparam logic [7:0] c_rpar  = 8'h29;
    localparam logic [7:0] c_equal = 8'h3D;

    typedef enum logic [2:0] {
        S_OPND  = 3'd0,
        S_OP    = 3'd1,
        S_PD1   = 3'd2,
        S_PO1   = 3'd3,
        S_PD2   = 3'd4,
        S_PO2   = 3'd5,
        S_DRAIN = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ascii_digit.sv
//------------------------------------------------------------------------------
// ascii_digit : classifies an ASCII character as a decimal digit and decodes it
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ascii_digit
    import expr_pkg::*;
(
    input  logic [7:0] in,
    output logic       is_digit,
    output logic [3:0] val
);

    assign is_digit = (in >= c_zero) && (in <= c_nine);
    // '0'..'9' are 0x30..0x39, so the low nibble is the value
    assign val      = is_digit ? in[3:0] : 4'd0;

endmodule

`default_nettype wire

// File: rtl/expr_eval.sv
//------------------------------------------------------------------------------
// expr_eval : streaming ASCII evaluator for '+'/'*' expressions with one paren level
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module expr_eval
    import expr_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in,
    output logic [15:0] result,
    output logic        done,
    output logic        err,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [15:0] sum_q, term_q;
    logic        mulpend_q;
    logic [15:0] sh_sum_q, sh_term_q;
    logic        sh_mulpend_q;
    logic [15:0] result_q;
    logic        done_q, err_q, busy_q;

    logic        is_digit;
    logic [3:0]  dig_val;
    logic        is_op, is_plus, is_star, is_lpar, is_rpar, is_equal;
    logic [15:0] dig_ext, total_d, term_dig_d, term_par_d;

    ascii_digit u_digit (
        .in       (in),
        .is_digit (is_digit),
        .val      (dig_val)
    );

    assign is_plus  = (in == c_plus);
    assign is_star  = (in == c_star);
    assign is_op    = is_plus || is_star;
    assign is_lpar  = (in == c_lpar);
    assign is_rpar  = (in == c_rpar);
    assign is_equal = (in == c_equal);

    assign dig_ext    = {12'd0, dig_val};
    assign total_d    = sum_q + term_q;
    assign term_dig_d = mulpend_q ? (term_q * dig_ext) : dig_ext;
    // a closing paren acts as an operand whose value is the inner total
    assign term_par_d = sh_mulpend_q ? (sh_term_q * total_d) : total_d;

    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                S_OPND:  state_d = is_digit ? S_OP : (is_lpar ? S_PD1 : S_DRAIN);
                S_OP:    state_d = (is_op || is_equal) ? S_OPND : S_DRAIN;
                S_PD1:   state_d = is_digit ? S_PO1 : S_DRAIN;
                S_PO1:   state_d = is_op ? S_PD2 : S_DRAIN;
                S_PD2:   state_d = is_digit ? S_PO2 : S_DRAIN;
                S_PO2:   state_d = is_op ? S_PD2 : (is_rpar ? S_OP : S_DRAIN);
                S_DRAIN: state_d = is_equal ? S_OPND : S_DRAIN;
                default: state_d = S_OPND;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= S_OPND;
            sum_q        <= 16'd0;
            term_q       <= 16'd0;
            mulpend_q    <= 1'b0;
            sh_sum_q     <= 16'd0;
            sh_term_q    <= 16'd0;
            sh_mulpend_q <= 1'b0;
            result_q     <= 16'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (in_valid) begin
                state_q <= state_d;
                busy_q  <= (state_d != S_OPND);
                err_q   <= (state_d == S_DRAIN) && (state_q != S_DRAIN);
                case (state_q)
                    S_OPND: begin
                        if (is_digit) begin
                            term_q <= term_dig_d;
                        end else if (is_lpar) begin
                            sh_sum_q     <= sum_q;
                            sh_term_q    <= term_q;
                            sh_mulpend_q <= mulpend_q;
                            sum_q        <= 16'd0;
                            mulpend_q    <= 1'b0;
                        end
                    end
                    S_PD1, S_PD2: begin
                        if (is_digit) term_q <= term_dig_d;
                    end
                    S_OP, S_PO1, S_PO2: begin
                        if (is_plus) begin
                            sum_q     <= total_d;
                            mulpend_q <= 1'b0;
                        end else if (is_star) begin
                            mulpend_q <= 1'b1;
                        end else if (is_equal && state_q == S_OP) begin
                            result_q  <= total_d;
                            done_q    <= 1'b1;
                            sum_q     <= 16'd0;
                            mulpend_q <= 1'b0;
                        end else if (is_rpar && state_q == S_PO2) begin
                            sum_q     <= sh_sum_q;
                            mulpend_q <= sh_mulpend_q;
                            term_q    <= term_par_d;
                        end
                    end
                    S_DRAIN: begin
                        if (is_equal) begin
                            sum_q     <= 16'd0;
                            mulpend_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign err    = err_q;
    assign busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_expr_eval.sv
//------------------------------------------------------------------------------
// tb_expr_eval : directed self-checking bench for expr_eval
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_expr_eval;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in = 8'h00;
    logic [15:0] result;
    logic        done, err, busy;

    int n_cmp = 0;
    int n_bad = 0;

    expr_eval dut (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in       (in),
        .result   (result),
        .done     (done),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // one character, then 'gap' idle cycles; done/err seen anywhere are accumulated
    task automatic send_char(input logic [7:0] c, input int gap,
                             inout int nd, inout int ne, output logic e_now);
        @(negedge clk);
        in_valid = 1'b1;
        in       = c;
        @(posedge clk);
        #1;
        nd += int'(done);
        ne += int'(err);
        e_now = err;
        @(negedge clk);
        in_valid = 1'b0;
        in       = 8'h20;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            nd += int'(done);
            ne += int'(err);
        end
    endtask

    task automatic send_str(input string s, input int gap, output int nd, output int ne);
        logic e;
        nd = 0;
        ne = 0;
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i], gap, nd, ne, e);
        end
        // one trailing cycle catches a pulse that lingers too long
        @(posedge clk);
        #1;
        nd += int'(done);
        ne += int'(err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   nd, ne;
        logic e;

        #1;
        chk("rst_result", result, 0);
        chk("rst_done",   done,   0);
        chk("rst_err",    err,    0);
        chk("rst_busy",   busy,   0);
        repeat (3) @(negedge clk);
        clr = 1'b0;

        send_str("2+3*4=", 0, nd, ne);
        chk("prec_result", result, 14);
        chk("prec_done",   nd, 1);
        chk("prec_err",    ne, 0);
        chk("prec_busy",   busy, 0);

        send_str("(1+2)*3=", 0, nd, ne);
        chk("paren1_result", result, 9);
        chk("paren1_done",   nd, 1);
        send_str("4*(2+3*2)+1=", 1, nd, ne);
        chk("paren2_result", result, 33);
        chk("paren2_done",   nd, 1);
        chk("paren2_err",    ne, 0);

        send_str("9*9*9*9*9*9=", 0, nd, ne);
        chk("wrap_result", result, 7153);

        send_str("0*5+7+2*(3*3+1)=", 0, nd, ne);
        chk("mixed_result", result, 27);

        // ')' right after a single digit is illegal
        nd = 0;
        ne = 0;
        send_char("(", 0, nd, ne, e);
        send_char("3", 0, nd, ne, e);
        chk("noop_busy", busy, 1);
        send_char(")", 0, nd, ne, e);
        chk("noop_err_edge", e, 1);
        send_char("=", 0, nd, ne, e);
        chk("noop_err_cnt", ne, 1);
        chk("noop_done",    nd, 0);
        chk("noop_result",  result, 27);
        chk("noop_busy_end", busy, 0);
        send_str("1=", 0, nd, ne);
        chk("after_err_result", result, 1);

        send_str("2+a5=", 0, nd, ne);
        chk("bad_char_err",    ne, 1);
        chk("bad_char_done",   nd, 0);
        chk("bad_char_result", result, 1);

        send_str("2+3", 2, nd, ne);
        chk("partial_busy", busy, 1);
        chk("partial_done", nd, 0);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("async_clr_result", result, 0);
        chk("async_clr_busy",   busy,   0);
        @(negedge clk);
        clr = 1'b0;
        send_str("4=", 3, nd, ne);
        chk("post_clr_result", result, 4);
        chk("post_clr_done",   nd, 1);
        chk("post_clr_err",    ne, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
